if_neuron_array: RTL
====================

// Module: if_neuron_array
// PURPOSE
//  Time-multiplexed integrate-and-fire engine for N neurons with on-chip state.
//  Consumes a stream of synaptic, time-step and time-reference events, keeps the
//  signed membrane potential and the saturating spike count for every neuron,
//  and emits an address stream of fired neurons.
//  Sits between the synaptic event router (upstream) and the spike/weight-update
//  logic of the FF training loop (downstream).
// PARAMETERS
//  NEUR_AW  8   neuron address width; N = 2**NEUR_AW neurons
//  MEM_W    12  membrane potential width (signed two's complement)
//  WGT_W    8   synaptic weight width (signed)
//  CNT_W    7   per-neuron spike count width (unsigned)
// PORTS
//  CLK          in   1        clock, all logic on rising edge
//  RST          in   1        synchronous reset, active-high
//  evt_valid    in   1        event present
//  evt_ready    out  1        event accepted when evt_valid & evt_ready
//  evt_type     in   2        0 SYN, 1 TSTEP, 2 TREF, 3 reserved (accepted, ignored)
//  evt_addr     in   NEUR_AW  target neuron (SYN only)
//  evt_weight   in   WGT_W    signed weight (SYN only)
//  param_thr    in   MEM_W    signed firing threshold, static while busy
//  param_leak   in   MEM_W    unsigned leak per time step (used only with LEAK_EN)
//  spk_valid    out  1        fired-neuron address valid
//  spk_ready    in   1        downstream accepts spike
//  spk_addr     out  NEUR_AW  fired neuron index
//  cnt_rd_addr  in   NEUR_AW  spike-count read address
//  cnt_rd_data  out  CNT_W    spike count, registered, 1-cycle read latency
//  busy         out  1        high in SCAN or CLEAR
// BEHAVIOUR
//  - FSM: IDLE, SCAN, CLEAR. evt_ready = (state==IDLE). busy = ~evt_ready.
//  - Reset: FSM to IDLE, index = 0, all potentials and counts = 0,
//    spk_valid = 0, spk_addr = 0, cnt_rd_data = 0.
//    RST mid-SCAN/CLEAR aborts immediately; the in-flight spike is dropped.
//  - SYN accepted in IDLE: vm[addr] <= sat(vm[addr] + sext(weight)) next cycle.
//    Saturation to [-2**(MEM_W-1), 2**(MEM_W-1)-1], never wraps. Count unchanged.
//    Back-to-back SYN to the same addr every cycle must accumulate correctly.
//  - TSTEP accepted in IDLE: SCAN idx = 0..N-1, one neuron per cycle.
//    fire = (vm[idx] >= param_thr) & ~vm[idx][MEM_W-1].
//    fire: spk_valid = 1, spk_addr = idx (combinational from FSM and idx).
//      Hold until spk_ready, then vm <= 0 and cnt <= min(cnt+1, 2**CNT_W-1),
//      and idx advances. No update occurs while stalled.
//    no fire: vm unchanged (see LEAK_EN), idx advances, spk_valid = 0.
//    After idx == N-1 completes, return to IDLE. Total N cycles plus stall cycles.
//  - TREF accepted in IDLE: CLEAR zeroes vm and cnt at idx, one per cycle,
//    for N cycles, then IDLE. No spikes are emitted in CLEAR.
//  - cnt_rd is read-before-write: a read of the neuron being updated in the same
//    cycle returns the old count. The read is legal in any state.
//  - Reserved evt_type: consumed in one cycle with no state change.
// CONFIGURATION
//  LEAK_EN defined: in SCAN, a non-firing neuron decays toward 0 by param_leak.
//    vm > 0: vm <= max(vm - leak, 0). vm < 0: vm <= min(vm + leak, 0).
//  LEAK_EN undefined: a non-firing neuron keeps vm. param_leak is ignored.
// STRUCTURE
//  Package snn_ff_pkg: evt_type encodings (EVT_SYN/EVT_TSTEP/EVT_TREF),
//    FSM state enum, default widths.
//  Sub-module if_neuron_update: combinational per-neuron datapath
//    (saturating add, fire compare, leak, count increment), shared by the SYN
//    and SCAN paths. The top level holds the FSM, index counter, vm/cnt arrays
//    and the handshakes.
// TESTING
//  1. thr=10; SYN n3 w=+6 twice; TSTEP with spk_ready=1 -> exactly one spike,
//     addr 3; vm[3]=0; cnt[3]=1; busy for 256 cycles.
//  2. SYN n5 w=+127 x20 -> vm[5]=2047 (saturated). SYN n6 w=-128 x20 -> vm[6]=-2048.
//  3. Fire n0 and n1; hold spk_ready=0 for 5 cycles on n0 -> spk_addr stays 0,
//     idx frozen, then n1 follows. No spike is lost or duplicated.
//  4. Force cnt[7] to 127, fire again -> cnt stays 127. TREF -> after 256
//     cycles all cnt and vm read 0.
//  5. Assert RST mid-SCAN at idx 100 -> next cycle IDLE, spk_valid=0,
//     evt_ready=1, all state 0.
//  6. LEAK_EN, leak=3: vm=+2 -> 0; vm=-7 -> -4; vm=9, thr=20 -> 6.
//     Without LEAK_EN the same three cases leave vm unchanged.

Source files
------------

// File: rtl/snn_ff_pkg.sv
// Shared definitions for the integrate-and-fire neuron engine: event
// encodings, scan FSM states and default datapath widths.
package snn_ff_pkg;

    localparam int NEUR_AW_DEF = 8;
    localparam int MEM_W_DEF   = 12;
    localparam int WGT_W_DEF   = 8;
    localparam int CNT_W_DEF   = 7;

    localparam logic [1:0] EVT_SYN   = 2'd0;
    localparam logic [1:0] EVT_TSTEP = 2'd1;
    localparam logic [1:0] EVT_TREF  = 2'd2;
    localparam logic [1:0] EVT_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/if_neuron_update.sv
// Combinational per-neuron datapath: saturating synaptic add, fire compare,
// optional leak toward zero (enabled by defining LEAK_EN) and count increment.
module if_neuron_update
    import snn_ff_pkg::*;
#(
    parameter int MEM_W = MEM_W_DEF,
    parameter int WGT_W = WGT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic signed [MEM_W-1:0] vm_i,
    input  logic signed [WGT_W-1:0] weight_i,
    input  logic signed [MEM_W-1:0] thr_i,
    input  logic        [MEM_W-1:0] leak_i,
    input  logic        [CNT_W-1:0] cnt_i,
    output logic        [MEM_W-1:0] vm_syn_o,
    output logic        [MEM_W-1:0] vm_idle_o,
    output logic                    fire_o,
    output logic        [CNT_W-1:0] cnt_inc_o
);

    logic [MEM_W:0] sum_s;

    // One guard bit is enough to detect overflow of a potential plus a narrower weight.
    assign sum_s = {vm_i[MEM_W-1], vm_i} + {{(MEM_W+1-WGT_W){weight_i[WGT_W-1]}}, weight_i};

    // Clamp the synaptic sum to the signed potential range.
    always_comb begin
        if (sum_s[MEM_W] != sum_s[MEM_W-1]) begin
            if (sum_s[MEM_W]) begin
                vm_syn_o = {1'b1, {(MEM_W-1){1'b0}}};
            end else begin
                vm_syn_o = {1'b0, {(MEM_W-1){1'b1}}};
            end
        end else begin
            vm_syn_o = sum_s[MEM_W-1:0];
        end
    end

    assign fire_o    = (vm_i >= thr_i) && !vm_i[MEM_W-1];
    assign cnt_inc_o = (&cnt_i) ? cnt_i : cnt_i + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef LEAK_EN
    logic [MEM_W+1:0] dec_s;
    logic [MEM_W+1:0] inc_s;

    assign dec_s = {{2{vm_i[MEM_W-1]}}, vm_i} - {2'b00, leak_i};
    assign inc_s = {{2{vm_i[MEM_W-1]}}, vm_i} + {2'b00, leak_i};

    // Decay toward zero without crossing it.
    always_comb begin
        if (!vm_i[MEM_W-1] && (vm_i != {MEM_W{1'b0}})) begin
            if (dec_s[MEM_W+1]) begin
                vm_idle_o = {MEM_W{1'b0}};
            end else begin
                vm_idle_o = dec_s[MEM_W-1:0];
            end
        end else if (vm_i[MEM_W-1]) begin
            if (!inc_s[MEM_W+1]) begin
                vm_idle_o = {MEM_W{1'b0}};
            end else begin
                vm_idle_o = inc_s[MEM_W-1:0];
            end
        end else begin
            vm_idle_o = vm_i;
        end
    end
`else
    logic leak_unused_s;

    assign leak_unused_s = ^leak_i;
    assign vm_idle_o     = vm_i;
`endif

endmodule

// File: rtl/if_neuron_array.sv
// Time-multiplexed integrate-and-fire engine with on-chip potential and spike
// count storage; leak on non-firing neurons is built in when LEAK_EN is defined.
module if_neuron_array
    import snn_ff_pkg::*;
#(
    parameter int NEUR_AW = NEUR_AW_DEF,
    parameter int MEM_W   = MEM_W_DEF,
    parameter int WGT_W   = WGT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               evt_valid,
    output logic               evt_ready,
    input  logic [1:0]         evt_type,
    input  logic [NEUR_AW-1:0] evt_addr,
    input  logic [WGT_W-1:0]   evt_weight,
    input  logic [MEM_W-1:0]   param_thr,
    input  logic [MEM_W-1:0]   param_leak,
    output logic               spk_valid,
    input  logic               spk_ready,
    output logic [NEUR_AW-1:0] spk_addr,
    input  logic [NEUR_AW-1:0] cnt_rd_addr,
    output logic [CNT_W-1:0]   cnt_rd_data,
    output logic               busy
);

    localparam int N = 2 ** NEUR_AW;

    state_e             state_q;
    logic [NEUR_AW-1:0] idx_q;
    logic [NEUR_AW-1:0] idx_d;
    logic [MEM_W-1:0]   vm_q  [N];
    logic [CNT_W-1:0]   cnt_q [N];
    logic [CNT_W-1:0]   cnt_rd_q;

    logic [NEUR_AW-1:0] upd_addr_s;
    logic [MEM_W-1:0]   vm_syn_s;
    logic [MEM_W-1:0]   vm_idle_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               fire_s;
    logic               last_s;
    logic               adv_s;

    // The single datapath serves the event address in IDLE and the scan index otherwise.
    assign upd_addr_s = (state_q == ST_IDLE) ? evt_addr : idx_q;
    assign idx_d      = idx_q + {{(NEUR_AW-1){1'b0}}, 1'b1};
    assign last_s     = (idx_q == {NEUR_AW{1'b1}});
    assign adv_s      = !fire_s || spk_ready;

    if_neuron_update #(
        .MEM_W (MEM_W),
        .WGT_W (WGT_W),
        .CNT_W (CNT_W)
    ) u_update (
        .vm_i      (vm_q[upd_addr_s]),
        .weight_i  (evt_weight),
        .thr_i     (param_thr),
        .leak_i    (param_leak),
        .cnt_i     (cnt_q[upd_addr_s]),
        .vm_syn_o  (vm_syn_s),
        .vm_idle_o (vm_idle_s),
        .fire_o    (fire_s),
        .cnt_inc_o (cnt_inc_s)
    );

    assign evt_ready   = (state_q == ST_IDLE);
    assign busy        = !evt_ready;
    assign spk_valid   = (state_q == ST_SCAN) && fire_s;
    assign spk_addr    = idx_q;
    assign cnt_rd_data = cnt_rd_q;

    // Sequencer: event dispatch, scan/clear walk over all neurons.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= {NEUR_AW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_valid) begin
                        case (evt_type)
                            EVT_TSTEP: begin
                                state_q <= ST_SCAN;
                                idx_q   <= {NEUR_AW{1'b0}};
                            end
                            EVT_TREF: begin
                                state_q <= ST_CLEAR;
                                idx_q   <= {NEUR_AW{1'b0}};
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    if (adv_s) begin
                        idx_q <= idx_d;
                        if (last_s) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    idx_q <= idx_d;
                    if (last_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= {NEUR_AW{1'b0}};
                end
            endcase
        end
    end

    // Neuron state storage and the read-before-write count port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                vm_q[i]  <= {MEM_W{1'b0}};
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            cnt_rd_q <= {CNT_W{1'b0}};
        end else begin
            cnt_rd_q <= cnt_q[cnt_rd_addr];
            case (state_q)
                ST_IDLE: begin
                    if (evt_valid && (evt_type == EVT_SYN)) begin
                        vm_q[upd_addr_s] <= vm_syn_s;
                    end
                end
                ST_SCAN: begin
                    if (fire_s) begin
                        if (spk_ready) begin
                            vm_q[idx_q]  <= {MEM_W{1'b0}};
                            cnt_q[idx_q] <= cnt_inc_s;
                        end
                    end else begin
                        vm_q[idx_q] <= vm_idle_s;
                    end
                end
                ST_CLEAR: begin
                    vm_q[idx_q]  <= {MEM_W{1'b0}};
                    cnt_q[idx_q] <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_rd_q <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
